// File: rtl/rf_pkg.sv
// Shared types and helpers for the multiport register file with its clear engine.
package rf_pkg;

  typedef enum logic {RF_IDLE, RF_CLEAR} rf_state_t;

  localparam int RF_MAX_DEPTH = 256;

  // True for addresses that map to a real, writable entry (entry 0 is hardwired zero).
  function automatic logic rf_addr_ok(input int unsigned addr, input int unsigned depth);
    return (addr != 0) && (addr < depth);
  endfunction

endpackage

// File: rtl/rf_wr_decoder.sv
// One-hot write strobe generator shared by the normal write port and the clear sweep.
module rf_wr_decoder #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             ena,
  input  logic [AW-1:0]    addr,
  output logic [DEPTH-1:0] strobe
);

  always_comb begin
    strobe = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ena && (addr == AW'(i))) strobe[i] = 1'b1;
    end
  end

endmodule

// File: rtl/rf_multiport_clr.sv
// Two-read / one-write register file with register 0 hardwired to zero and a sequential clear sweep.
// Optional macro RF_BYPASS_EN forwards an accepted write to a matching read port in the same cycle.
module rf_multiport_clr
  import rf_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we3,
  input  logic [AW-1:0]    wa3,
  input  logic [WIDTH-1:0] wd3,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  input  logic             clr_req,
  output logic             busy,
  output logic             clr_done,
  output logic             wr_rej
);

  rf_state_t        state;
  rf_state_t        state_nxt;
  logic [AW-1:0]    ptr;
  logic             sweep_last;
  logic             wr_ok;
  logic             wr_bad;
  logic             dec_ena;
  logic [AW-1:0]    dec_addr;
  logic [WIDTH-1:0] wdata;
  logic [DEPTH-1:0] strobe;
  logic             unused_strobe0;
  logic [WIDTH-1:0] mem [DEPTH];

  assign sweep_last = (ptr == AW'(DEPTH - 1));
  assign wr_ok      = we3 && !busy && rf_addr_ok(32'(wa3), DEPTH);
  // Writes to entry 0 are silently discarded; only out-of-range or busy-time writes are flagged.
  assign wr_bad     = we3 && (wa3 != '0) && (busy || !rf_addr_ok(32'(wa3), DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RF_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RF_IDLE:  if (clr_req)    state_nxt = RF_CLEAR;
      RF_CLEAR: if (sweep_last) state_nxt = RF_IDLE;
      default:                  state_nxt = RF_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RF_CLEAR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      clr_done <= 1'b0;
      wr_rej   <= 1'b0;
    end else begin
      if (state == RF_IDLE && clr_req) ptr <= AW'(1);
      else if (state == RF_CLEAR)      ptr <= ptr + AW'(1);
      clr_done <= (state == RF_CLEAR) && sweep_last;
      wr_rej   <= wr_bad;
    end
  end

  // The sweep borrows the write path: pointer as address, zero as data.
  assign dec_ena  = wr_ok || busy;
  assign dec_addr = busy ? ptr : wa3;
  assign wdata    = busy ? '0 : wd3;

  rf_wr_decoder #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_dec (
    .ena    (dec_ena),
    .addr   (dec_addr),
    .strobe (strobe)
  );

  assign unused_strobe0 = strobe[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (strobe[i]) mem[i] <= wdata;
      end
    end
  end

  function automatic logic [WIDTH-1:0] read_port(input logic [AW-1:0] ra);
    logic [WIDTH-1:0] val;
    val = '0;
    if (rf_addr_ok(32'(ra), DEPTH)) val = mem[ra];
`ifdef RF_BYPASS_EN
    if (wr_ok && (ra == wa3)) val = wd3;
`else
`endif
    return val;
  endfunction

  always_comb begin
    rd1 = read_port(ra1);
  end

  always_comb begin
    rd2 = read_port(ra2);
  end

endmodule
